// File: rtl/vec_assembler.sv
// Reassembles BUS_WIDTH sub-vectors into VECTOR_WIDTH fingerprints, pairs each with its popcount
// and queues the pairs in a show-ahead FIFO. Optional sticky overflow flag: VEC_ASM_OVERFLOW_EN.
module vec_assembler #(
  parameter int VECTOR_WIDTH  = 920,
  parameter int BUS_WIDTH     = 512,
  parameter int SUB_VECTOR_NO = 2,
  parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BUS_WIDTH-1:0]    i_SubVector,
  input  logic                    i_Valid,
  input  logic [CNT_WIDTH-1:0]    i_Cnt,
  input  logic                    i_CntNew,
  output logic [VECTOR_WIDTH-1:0] o_Vector,
  output logic [CNT_WIDTH-1:0]    o_Cnt,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic                    o_Full,
  output logic                    o_Overflow
);

  localparam int WC_W   = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int A_W    = (SUB_VECTOR_NO > 1) ? (SUB_VECTOR_NO - 1) * BUS_WIDTH : BUS_WIDTH;
  localparam int FULL_W = SUB_VECTOR_NO * BUS_WIDTH;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int E_W    = VECTOR_WIDTH + CNT_WIDTH;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SUB_VECTOR_NO - 1);

  logic [WC_W-1:0]         wcnt_q, wcnt_d;
  logic [A_W-1:0]          a_q, a_d;
  logic [VECTOR_WIDTH-1:0] s_q, s_d;
  logic                    s_full_q, s_full_d;
  logic [CNT_WIDTH-1:0]    c_q, c_d;
  logic                    c_full_q, c_full_d;
  logic [E_W-1:0]          mem_q [FIFO_DEPTH];
  logic [E_W-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;

  logic              last_w, commit_w, pop_w, push_w, full_w, ovf_event_w;
  logic [FULL_W-1:0] asm_w;
  logic [E_W-1:0]    head_w;

  // Full-width image of the fingerprint as it stands when the last word arrives.
  always_comb begin
    asm_w                          = '0;
    asm_w[A_W-1:0]                 = a_q;
    asm_w[FULL_W-1 -: BUS_WIDTH]   = i_SubVector;
  end

  generate
    if (FULL_W > VECTOR_WIDTH) begin : g_trim
      logic unused_hi;
      assign unused_hi = ^asm_w[FULL_W-1:VECTOR_WIDTH];
    end
  endgenerate

  assign last_w   = i_Valid & (wcnt_q == WC_LAST);
  assign commit_w = s_full_q & c_full_q;
  assign full_w   = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop_w    = (count_q != '0) & i_Ready;
  assign push_w   = commit_w & (~full_w | pop_w);

  assign ovf_event_w = (last_w & s_full_q & ~commit_w)
                     | (i_CntNew & c_full_q & ~commit_w)
                     | (commit_w & full_w & ~pop_w);

  // Loads are evaluated after the commit clear so a coinciding load keeps its flag set.
  always_comb begin
    wcnt_d   = wcnt_q;
    a_d      = a_q;
    s_d      = s_q;
    s_full_d = s_full_q;
    c_d      = c_q;
    c_full_d = c_full_q;
    if (commit_w) begin
      s_full_d = 1'b0;
      c_full_d = 1'b0;
    end
    if (i_Valid) begin
      if (last_w) begin
        wcnt_d   = '0;
        s_d      = asm_w[VECTOR_WIDTH-1:0];
        s_full_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + WC_W'(1);
        for (int k = 0; k < SUB_VECTOR_NO - 1; k++) begin
          if (wcnt_q == WC_W'(k)) a_d[k*BUS_WIDTH +: BUS_WIDTH] = i_SubVector;
        end
      end
    end
    if (i_CntNew) begin
      c_d      = i_Cnt;
      c_full_d = 1'b1;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_w) begin
      mem_d[wr_ptr_q] = {s_q, c_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_w) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt_q   <= '0;
      a_q      <= '0;
      s_q      <= '0;
      s_full_q <= 1'b0;
      c_q      <= '0;
      c_full_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wcnt_q   <= wcnt_d;
      a_q      <= a_d;
      s_q      <= s_d;
      s_full_q <= s_full_d;
      c_q      <= c_d;
      c_full_q <= c_full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_w   = mem_q[rd_ptr_q];
  assign o_Valid  = (count_q != '0);
  assign o_Full   = full_w;
  assign o_Vector = o_Valid ? head_w[E_W-1:CNT_WIDTH] : '0;
  assign o_Cnt    = o_Valid ? head_w[CNT_WIDTH-1:0] : '0;

`ifdef VEC_ASM_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb ovf_d = ovf_q | ovf_event_w;

  always_ff @(posedge clk) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign o_Overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_event_w;
  assign o_Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_vec_assembler.sv
// Scoreboard bench for vec_assembler: expected {vector, count} pairs are queued as fingerprints
// are driven and compared whenever the DUT hands an entry to the consumer.
module tb_vec_assembler;

  localparam int VW = 920;
  localparam int BW = 512;
  localparam int CW = $clog2(VW);
`ifdef VEC_ASM_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [BW-1:0] i_SubVector = '0;
  logic          i_Valid = 1'b0;
  logic [CW-1:0] i_Cnt = '0;
  logic          i_CntNew = 1'b0;
  logic [VW-1:0] o_Vector;
  logic [CW-1:0] o_Cnt;
  logic          o_Valid;
  logic          i_Ready = 1'b0;
  logic          o_Full;
  logic          o_Overflow;

  vec_assembler dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_SubVector (i_SubVector),
    .i_Valid     (i_Valid),
    .i_Cnt       (i_Cnt),
    .i_CntNew    (i_CntNew),
    .o_Vector    (o_Vector),
    .o_Cnt       (o_Cnt),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Full      (o_Full),
    .o_Overflow  (o_Overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [VW-1:0] q_vec [$];
  logic [CW-1:0] q_cnt [$];

  task automatic check_eq(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Consumer side: a pop happens at the next rising edge whenever o_Valid & i_Ready.
  always @(negedge clk) begin
    if (rstn && o_Valid && i_Ready) begin
      if (q_vec.size() == 0) begin
        check_eq("pop_with_empty_scoreboard", o_Valid, 1'b0);
      end else begin
        logic [VW-1:0] ev;
        logic [CW-1:0] ec;
        ev = q_vec.pop_front();
        ec = q_cnt.pop_front();
        check_eq("sb_vec", o_Vector, ev);
        check_eq("sb_cnt", o_Cnt, ec);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic word(input logic [BW-1:0] w, input bit cn, input logic [CW-1:0] c);
    i_Valid     = 1'b1;
    i_SubVector = w;
    i_CntNew    = cn;
    i_Cnt       = c;
    cyc();
    i_Valid  = 1'b0;
    i_CntNew = 1'b0;
  endtask

  task automatic cnt_only(input logic [CW-1:0] c);
    i_CntNew = 1'b1;
    i_Cnt    = c;
    cyc();
    i_CntNew = 1'b0;
  endtask

  function automatic logic [BW-1:0] rnd512();
    logic [BW-1:0] w;
    for (int i = 0; i < BW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [VW-1:0] mkvec(input logic [BW-1:0] w0, input logic [BW-1:0] w1);
    logic [2*BW-1:0] t;
    t = {w1, w0};
    return t[VW-1:0];
  endfunction

  task automatic expect_fp(input logic [BW-1:0] w0, input logic [BW-1:0] w1, input logic [CW-1:0] c);
    q_vec.push_back(mkvec(w0, w1));
    q_cnt.push_back(c);
  endtask

  task automatic fp(input logic [BW-1:0] w0, input logic [BW-1:0] w1, input logic [CW-1:0] c,
                    input bit accepted);
    if (accepted) expect_fp(w0, w1, c);
    word(w0, 1'b0, '0);
    word(w1, 1'b1, c);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    cyc(2);
    q_vec.delete();
    q_cnt.delete();
    rstn = 1'b1;
  endtask

  logic [BW-1:0] a, b;
  logic [BW-1:0] ones;
  int            seen;

  initial begin
    ones = '1;
    cyc(3);
    check_eq("rst_valid", o_Valid, 1'b0);
    check_eq("rst_full", o_Full, 1'b0);
    check_eq("rst_ovf", o_Overflow, 1'b0);
    check_eq("rst_vec", o_Vector, '0);
    check_eq("rst_cnt", o_Cnt, '0);
    rstn    = 1'b1;
    i_Ready = 1'b1;

    // basic pair, count alongside the last word
    expect_fp(ones, '0, CW'(512));
    word(ones, 1'b0, '0);
    word('0, 1'b1, CW'(512));
    check_eq("basic_valid_at_e", o_Valid, 1'b0);
    cyc();
    check_eq("basic_valid_at_e1", o_Valid, 1'b1);
    check_eq("basic_lo", o_Vector[511:0], ones);
    check_eq("basic_hi", o_Vector[919:512], '0);
    check_eq("basic_cnt", o_Cnt, 512);
    cyc();
    check_eq("empty_valid", o_Valid, 1'b0);
    check_eq("empty_vec", o_Vector, '0);
    check_eq("empty_cnt", o_Cnt, '0);

    // late count
    a = rnd512();
    b = rnd512();
    expect_fp(a, b, CW'(7));
    word(a, 1'b0, '0);
    word(b, 1'b0, '0);
    seen = int'(o_Valid);
    repeat (4) begin
      cyc();
      seen = seen | int'(o_Valid);
    end
    check_eq("late_no_early_push", seen, 0);
    cnt_only(CW'(7));
    check_eq("late_valid_at_f", o_Valid, 1'b0);
    cyc();
    check_eq("late_valid_at_f1", o_Valid, 1'b1);
    cyc(2);

    // sustained back-to-back stream
    for (int i = 0; i < 4; i++) fp(rnd512(), rnd512(), CW'(100 + i), 1'b1);
    cyc(4);
    check_eq("stream_no_ovf", o_Overflow, 1'b0);
    check_eq("stream_drained", q_vec.size(), 0);

    // fill the FIFO, then commit with a simultaneous pop, then drop one
    i_Ready = 1'b0;
    for (int i = 1; i <= 4; i++) fp(rnd512(), rnd512(), CW'(i), 1'b1);
    cyc(2);
    check_eq("fill_full", o_Full, 1'b1);
    check_eq("fill_valid", o_Valid, 1'b1);
    fp(rnd512(), rnd512(), CW'(5), 1'b1);
    i_Ready = 1'b1;
    cyc();
    i_Ready = 1'b0;
    check_eq("pop_push_full", o_Full, 1'b1);
    check_eq("pop_push_no_ovf", o_Overflow, 1'b0);
    fp(rnd512(), rnd512(), CW'(6), 1'b0);
    cyc(2);
    check_eq("drop_full", o_Full, 1'b1);
    check_eq("drop_ovf", o_Overflow, OVF_EN);
    i_Ready = 1'b1;
    cyc(6);
    check_eq("drain_empty", o_Valid, 1'b0);
    check_eq("drain_sb_empty", q_vec.size(), 0);

    // count overwrite
    reset_dut();
    i_Ready = 1'b1;
    cnt_only(CW'(5));
    cnt_only(CW'(9));
    check_eq("cnt_ovw_flag", o_Overflow, OVF_EN);
    a = rnd512();
    b = rnd512();
    expect_fp(a, b, CW'(9));
    word(a, 1'b0, '0);
    word(b, 1'b0, '0);
    cyc(3);
    check_eq("cnt_ovw_sb_empty", q_vec.size(), 0);

    // reset with a queued entry and a partial fingerprint
    i_Ready = 1'b0;
    fp(rnd512(), rnd512(), CW'(11), 1'b0);
    cyc(2);
    check_eq("pre_rst_valid", o_Valid, 1'b1);
    word(rnd512(), 1'b0, '0);
    rstn = 1'b0;
    cyc();
    check_eq("mid_rst_valid", o_Valid, 1'b0);
    check_eq("mid_rst_full", o_Full, 1'b0);
    check_eq("mid_rst_ovf", o_Overflow, 1'b0);
    check_eq("mid_rst_vec", o_Vector, '0);
    check_eq("mid_rst_cnt", o_Cnt, '0);
    rstn    = 1'b1;
    i_Ready = 1'b1;
    fp(rnd512(), rnd512(), CW'(33), 1'b1);
    cyc(3);
    check_eq("post_rst_sb_empty", q_vec.size(), 0);
    check_eq("post_rst_idle", o_Valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_assembler.md
# vec_assembler

Reassembles the `BUS_WIDTH`-wide sub-vector stream from the popcount stage into full `VECTOR_WIDTH` fingerprints. Pairs each fingerprint with its set-bit count and buffers the pairs in a small show-ahead FIFO with a valid/ready output. It sits directly downstream of the popcount stage (`cnt1`) and feeds the Tanimoto comparison stage.

## Interface

Parameters:

- `VECTOR_WIDTH`, 920, full fingerprint width in bits.
- `BUS_WIDTH`, 512, sub-vector width in bits.
- `SUB_VECTOR_NO`, 2, sub-vectors per fingerprint; must equal ceil(`VECTOR_WIDTH`/`BUS_WIDTH`).
- `CNT_WIDTH`, `$clog2(VECTOR_WIDTH)`, popcount width.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:

- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `i_SubVector` in `BUS_WIDTH`: sub-vector data.
- `i_Valid` in 1: `i_SubVector` valid this cycle.
- `i_Cnt` in `CNT_WIDTH`: popcount of the current fingerprint.
- `i_CntNew` in 1: single-cycle strobe; `i_Cnt` valid.
- `o_Vector` out `VECTOR_WIDTH`: FIFO head fingerprint.
- `o_Cnt` out `CNT_WIDTH`: FIFO head popcount.
- `o_Valid` out 1: FIFO not empty.
- `i_Ready` in 1: consumer accepts the head entry.
- `o_Full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `o_Overflow` out 1: sticky error flag.

## Operation

- **Word counter** `wcnt`, range 0..`SUB_VECTOR_NO`-1.
  - Increments on each `i_Valid` and wraps to 0 after `SUB_VECTOR_NO`-1.
  - Word k is placed at bits `[k*BUS_WIDTH +: BUS_WIDTH]`. Bits at or above `VECTOR_WIDTH` are discarded; with the defaults, the upper 104 bits of word 1 are dropped.
- **Assembly register A** holds words 0..`SUB_VECTOR_NO`-2.
- **Stage register S** (flag `s_full`):
  - The last word is loaded into S together with A, and `s_full` is set.
  - A may immediately begin collecting the next fingerprint.
- **Count register C** (flag `c_full`) is loaded from `i_Cnt` on `i_CntNew`. The count may arrive before, with, or after the last word.
- **Commit:** when `s_full & c_full`, push {S, C} into the FIFO on the next edge and clear both flags.
  - If a load of S or C coincides with the clearing commit, the load wins and its flag stays set.
- **Stage overwrite:** last word arrives while `s_full` is set and no commit happens at that edge → S is overwritten and an overflow event is raised.
- **Count overwrite:** `i_CntNew` arrives while `c_full` is set and no commit happens at that edge → C is overwritten and an overflow event is raised.
- **FIFO full at commit:**
  - Without a simultaneous pop: the entry is dropped, both flags are cleared, and an overflow event is raised.
  - With a simultaneous pop: the push is accepted.
- **Pop** when `o_Valid & i_Ready`. Push into an empty FIFO is not bypassed.
- **Empty FIFO:** `o_Vector` and `o_Cnt` are driven to 0.

## Timing

- **Reset values:** `wcnt`=0, `s_full`=`c_full`=0, FIFO empty, `o_Valid`=0, `o_Full`=0, `o_Overflow`=0, `o_Vector`=0, `o_Cnt`=0.
- **Latency:** with the last word and count both sampled at edge E, the FIFO write occurs at E+1 and `o_Valid`=1 after E+1. If the count arrives later at edge F, `o_Valid`=1 after F+1.
- **Throughput:** one fingerprint per `SUB_VECTOR_NO` input cycles sustained, with no stall while `i_Ready`=1.
- **Reset mid-fingerprint:** partial words, S, C and all FIFO contents are discarded. The next `i_Valid` is treated as word 0.
- **Backpressure:** the block has no input ready. Input backpressure is the upstream's responsibility via `o_Full`.

## Configuration

- `VEC_ASM_OVERFLOW_EN` defined:
  - Each overflow event sets `o_Overflow`, which stays set until reset.
- `VEC_ASM_OVERFLOW_EN` undefined:
  - `o_Overflow` is tied to 0 and overflow events are silently discarded.
  - Data-path behaviour is identical in both cases.

## Test plan

- **Basic pair:** word0=all-1s, word1=all-0s, `i_CntNew` with `i_Cnt`=512 on the same cycle as word1 → one cycle later `o_Valid`=1, `o_Vector[511:0]`=all-1s, `o_Vector[919:512]`=0, `o_Cnt`=512.
- **Late count:** last word at cycle 10, `i_CntNew` (`i_Cnt`=7) at cycle 15 → `o_Valid` rises after the edge of cycle 16. No entry is pushed before that.
- **FIFO fill:** `i_Ready`=0, push 4 fingerprints → `o_Full`=1. A 5th fingerprint is dropped and `o_Overflow`=1 (macro defined). Draining returns the 4 entries in order, with counts 1,2,3,4.
- **Full with pop:** FIFO full, commit and pop on the same edge → push accepted, `o_Full` stays 1, `o_Overflow` stays 0.
- **Count overwrite:** two `i_CntNew` strobes (5, then 9) before the last word → `o_Overflow`=1 and the committed `o_Cnt`=9.
- **Reset:** `rstn`=0 after word0 only → all outputs return to reset values. The next two words assemble correctly into a new fingerprint.
